// File: rtl/data_stall_shim.sv
// Single-outstanding shim between the RI5CY data port and the ram wrapper data port.
// Latency: grant at request+1+Dg, response at ram rvalid+1+Dr (Dg/Dr = 0 when stall_en_i low).
// Backpressure: ram grant withholding stretches ISSUE; core requests are ignored until IDLE.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   stall_en_i                1 = apply GNT_DELAY / RVALID_DELAY, 0 = no extra delay
//   core_req_i .. core_wdata_i   core-side request and attributes
//   core_gnt_o, core_rvalid_o, core_rdata_o   core-side grant and response
//   mem_req_o .. mem_wdata_o     ram-side request, driven from latched attributes
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i      ram-side grant and response
module data_stall_shim #(
  parameter int unsigned ADDR_WIDTH   = 22,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned GNT_DELAY    = 2,
  parameter int unsigned RVALID_DELAY = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    stall_en_i,
  input  logic                    core_req_i,
  input  logic [ADDR_WIDTH-1:0]   core_addr_i,
  input  logic                    core_we_i,
  input  logic [DATA_WIDTH/8-1:0] core_be_i,
  input  logic [DATA_WIDTH-1:0]   core_wdata_i,
  output logic                    core_gnt_o,
  output logic                    core_rvalid_o,
  output logic [DATA_WIDTH-1:0]   core_rdata_o,
  output logic                    mem_req_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam logic [3:0] GNT_D = 4'(GNT_DELAY);
  localparam logic [3:0] RV_D  = 4'(RVALID_DELAY);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GNT,
    ISSUE,
    WAIT_RESP,
    HOLD,
    RESP
  } state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic [3:0]              dr_q;      // response delay sampled when leaving IDLE
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    we_q;
  logic [DATA_WIDTH/8-1:0] be_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    req_q;     // high exactly while in ISSUE
  logic                    rvalid_q;  // high exactly while in RESP

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      dr_q     <= 4'd0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      req_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (core_req_i) begin
            addr_q  <= core_addr_i;
            we_q    <= core_we_i;
            be_q    <= core_be_i;
            wdata_q <= core_wdata_i;
            // Both delays are frozen here; stall_en_i is not looked at again
            // until the next request leaves IDLE.
            dr_q    <= stall_en_i ? RV_D : 4'd0;
            if (stall_en_i && (GNT_D != 4'd0)) begin
              state <= WAIT_GNT;
              cnt   <= GNT_D - 4'd1;
            end else begin
              state <= ISSUE;
              req_q <= 1'b1;
            end
          end
        end

        WAIT_GNT: begin
          if (cnt == 4'd0) begin
            state <= ISSUE;
            req_q <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        ISSUE: begin
          if (mem_gnt_i) begin
            state <= WAIT_RESP;
            req_q <= 1'b0;
          end
        end

        WAIT_RESP: begin
          // Writes also wait here; their captured rdata is meaningless.
          if (mem_rvalid_i) begin
            rdata_q <= mem_rdata_i;
            if (dr_q != 4'd0) begin
              state <= HOLD;
              cnt   <= dr_q - 4'd1;
            end else begin
              state    <= RESP;
              rvalid_q <= 1'b1;
            end
          end
        end

        HOLD: begin
          if (cnt == 4'd0) begin
            state    <= RESP;
            rvalid_q <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        RESP: begin
          // A request present now is only seen once back in IDLE.
          state    <= IDLE;
          rvalid_q <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          req_q    <= 1'b0;
          rvalid_q <= 1'b0;
        end
      endcase
    end
  end

  // Grant is passed straight through while the request is on the ram port.
  assign core_gnt_o    = req_q & mem_gnt_i;
  assign core_rvalid_o = rvalid_q;
  assign core_rdata_o  = rdata_q;

  assign mem_req_o   = req_q;
  assign mem_addr_o  = addr_q;
  assign mem_we_o    = we_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;

endmodule
